// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the pipelined RISC-V core.
// Owns the fetch PC and issues in-order word requests to instruction memory.
// Responses are buffered in a small fetch queue; the queue head drives the
// IF/ID interface. A redirect from a later stage flushes the queue and
// restarts fetch. Responses to requests issued before a redirect are dropped.
// Optional feature: define IF_PERF_CNT_EN to add the perf_fetch_cnt and
// perf_stall_cnt performance counter outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_req_addr,
    input  logic        im_resp_valid,
    input  logic [31:0] im_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned PTR_W    = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FQ_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      fq_pc_q [FQ_DEPTH];
    logic [31:0]      fq_pc_d [FQ_DEPTH];
    logic [31:0]      fq_inst_q [FQ_DEPTH];
    logic [31:0]      fq_inst_d [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             pop;
    logic             accept;
    logic             push;
    logic             drop;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      redirect_pc_aligned;

    // Handshakes, request credit and the IF/ID view of the queue head.
    always_comb begin
        id_valid            = (count_q != '0);
        pop                 = id_valid & id_ready;
        // Entries held plus requests outstanding, counting the head as free
        // when ID takes it this cycle; this bounds the queue so it never overflows.
        credit_used         = {1'b0, count_q} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, pop};
        im_req_valid        = !reset && !redirect_valid && (credit_used < DEPTH_W);
        im_req_addr         = fetch_pc_q;
        accept              = im_req_valid & im_req_ready;
        drop                = im_resp_valid && (drop_cnt_q != '0);
        push                = im_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
        redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
        id_pc               = fq_pc_q[rd_ptr_q];
        id_inst             = id_valid ? fq_inst_q[rd_ptr_q] : NOP_INST;
    end

    // Next-state for PCs, queue storage/pointers and the in-flight bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        fq_pc_d    = fq_pc_q;
        fq_inst_d  = fq_inst_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        // No request is accepted during a redirect, so this also holds then.
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(im_resp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still outstanding is stale; a response landing now is
            // discarded immediately and so is not counted again.
            drop_cnt_d = inflight_q - CNT_W'(im_resp_valid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (push) begin
                fq_pc_d[wr_ptr_q]   = resp_pc_q;
                fq_inst_d[wr_ptr_q] = im_resp_data;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
                resp_pc_d           = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            fq_pc_q    <= '{default: RESET_PC};
            fq_inst_q  <= '{default: NOP_INST};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            fq_pc_q    <= fq_pc_d;
            fq_inst_q  <= fq_inst_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    // Counters see the raw ID handshake, independent of any redirect.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q + 32'(pop);
        perf_stall_cnt_d = perf_stall_cnt_q + 32'(id_valid & !id_ready);
        perf_fetch_cnt   = perf_fetch_cnt_q;
        perf_stall_cnt   = perf_stall_cnt_q;
    end

    // Performance counter registers; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: self-checking bench for if_fetch_stage.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
// Perf-counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          D        = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        im_req_valid;
    logic        im_req_ready = 1'b0;
    logic [31:0] im_req_addr;
    logic        im_resp_valid = 1'b0;
    logic [31:0] im_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_fetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .im_req_valid  (im_req_valid),
        .im_req_ready  (im_req_ready),
        .im_req_addr   (im_req_addr),
        .im_resp_valid (im_resp_valid),
        .im_resp_data  (im_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a simple address-derived word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    // ---------------- behavioural reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } pend_t;

    pend_t       pend[$];   // requests accepted by memory, oldest first
    int          cyc = 0;
    int          epoch = 0; // program-stream generation, bumped by redirect
    int          occ = 0;   // instructions of the current stream awaiting ID
    int          last_due = 0;
    logic [31:0] exp_pc = RESET_PC;    // next PC ID should receive
    logic [31:0] model_fetch = RESET_PC;
    int          n_pops = 0;
    int          n_stalls = 0;
    bit          prev_stuck = 1'b0;

    task automatic model_clear();
        pend.delete();
        occ         = 0;
        epoch       = 0;
        last_due    = 0;
        exp_pc      = RESET_PC;
        model_fetch = RESET_PC;
        n_pops      = 0;
        n_stalls    = 0;
        prev_stuck  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        im_req_ready   = 1'b0;
        im_resp_valid  = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", {31'b0, im_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, RESET_PC);
        chk("rst_id_inst", id_inst, NOP);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        model_clear();
    endtask

    // One clock cycle driven by the memory model and checked against the stream model.
    task automatic step(input bit rdy, input bit idr, input bit redir,
                        input logic [31:0] rpc, input int lat);
        bit    pop_m;
        bit    exp_req;
        bit    acc;
        int    used;
        pend_t e;
        @(negedge clk);
        reset          = 1'b0;
        im_req_ready   = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            im_resp_valid = 1'b1;
            im_resp_data  = mem_word(pend[0].addr);
        end else begin
            im_resp_valid = 1'b0;
            im_resp_data  = $urandom;
        end
        #1;
        pop_m   = (occ > 0) && idr;
        used    = occ + pend.size() - (pop_m ? 1 : 0);
        exp_req = !redir && (used < D);
        chk("req_valid", {31'b0, im_req_valid}, {31'b0, exp_req});
        chk("id_valid", {31'b0, id_valid}, {31'b0, (occ > 0)});
        if (im_req_valid) chk("req_addr", im_req_addr, model_fetch);
        if (!id_valid) chk("idle_inst", id_inst, NOP);
        if (prev_stuck && !redir) chk("req_held", {31'b0, im_req_valid}, 32'd1);
        if (pop_m && !redir) begin
            chk("pop_pc", id_pc, exp_pc);
            chk("pop_inst", id_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, n_pops);
        chk("perf_stall", perf_stall_cnt, n_stalls);
`endif
        n_pops   += pop_m ? 1 : 0;
        n_stalls += ((occ > 0) && !idr) ? 1 : 0;

        acc = im_req_valid && rdy;
        if (im_resp_valid) begin
            e = pend.pop_front();
            if (!redir && e.epoch == epoch) occ++;
        end
        if (pop_m && !redir) occ--;
        if (redir) begin
            epoch++;
            occ         = 0;
            exp_pc      = {rpc[31:2], 2'b00};
            model_fetch = {rpc[31:2], 2'b00};
        end else if (acc) begin
            e.addr   = model_fetch;
            e.due    = (cyc + lat > last_due) ? cyc + lat : last_due;
            e.epoch  = epoch;
            last_due = e.due;
            pend.push_back(e);
            model_fetch = model_fetch + 32'd4;
        end
        prev_stuck = im_req_valid && !rdy && !redir;
        cyc++;
    endtask

    // ---------------- cycle-exact vector table ----------------
    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          redir;
        logic [31:0] rpc;
        bit          idr;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input bit rv, input logic [31:0] raddr, input bit redir,
                                input logic [31:0] rpc, input bit e_rv,
                                input logic [31:0] e_addr, input bit e_iv,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rdy = 1'b1; v.rv = rv; v.rd = mem_word(raddr); v.redir = redir; v.rpc = rpc;
        v.idr = 1'b1; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        bit          rdy, idr, redir;
        logic [31:0] rpc;
        int          pops_before;

        // Zero-wait memory, then a redirect with a stale response in flight,
        // then a redirect colliding with a response and a pop.
        tbl[0]  = mk(0, 32'h000, 0, 32'h000, 1, 32'h000, 0, 32'h000);
        tbl[1]  = mk(1, 32'h000, 0, 32'h000, 1, 32'h004, 0, 32'h000);
        tbl[2]  = mk(1, 32'h004, 0, 32'h000, 1, 32'h008, 1, 32'h000);
        tbl[3]  = mk(1, 32'h008, 0, 32'h000, 1, 32'h00C, 1, 32'h004);
        tbl[4]  = mk(1, 32'h00C, 0, 32'h000, 1, 32'h010, 1, 32'h008);
        tbl[5]  = mk(1, 32'h010, 0, 32'h000, 1, 32'h014, 1, 32'h00C);
        tbl[6]  = mk(0, 32'h000, 1, 32'h101, 0, 32'h000, 1, 32'h010);
        tbl[7]  = mk(1, 32'h014, 0, 32'h000, 1, 32'h100, 0, 32'h000);
        tbl[8]  = mk(1, 32'h100, 0, 32'h000, 1, 32'h104, 0, 32'h000);
        tbl[9]  = mk(1, 32'h104, 0, 32'h000, 1, 32'h108, 1, 32'h100);
        tbl[10] = mk(1, 32'h108, 1, 32'h200, 0, 32'h000, 1, 32'h104);
        tbl[11] = mk(0, 32'h000, 0, 32'h000, 1, 32'h200, 0, 32'h000);
        tbl[12] = mk(1, 32'h200, 0, 32'h000, 1, 32'h204, 0, 32'h000);
        tbl[13] = mk(1, 32'h204, 0, 32'h000, 1, 32'h208, 1, 32'h200);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            reset          = 1'b0;
            im_req_ready   = tbl[i].rdy;
            im_resp_valid  = tbl[i].rv;
            im_resp_data   = tbl[i].rd;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            id_ready       = tbl[i].idr;
            #1;
            chk($sformatf("tbl%0d_req_valid", i), {31'b0, im_req_valid}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), im_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_id_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_iv});
            if (tbl[i].e_iv) chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_id_inst", i), id_inst,
                tbl[i].e_iv ? mem_word(tbl[i].e_pc) : NOP);
        end

        // ID stall fills the queue and halts requests; release resumes in order.
        do_reset();
        repeat (6) step(1, 1, 0, 32'h0, 1);
        repeat (6) step(1, 0, 0, 32'h0, 1);
        chk("stall_req_off", {31'b0, im_req_valid}, 32'd0);
        chk("stall_id_valid", {31'b0, id_valid}, 32'd1);
        chk("stall_head_pc", id_pc, exp_pc);
        repeat (8) step(1, 1, 0, 32'h0, 1);

        // Memory not ready with fetch PC at 0x8: address held, queue drains.
        do_reset();
        repeat (2) step(1, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0, 1);
            chk("hold_addr", im_req_addr, 32'h8);
            chk("hold_valid", {31'b0, im_req_valid}, 32'd1);
        end
        chk("drained", {31'b0, id_valid}, 32'd0);
        repeat (4) step(1, 1, 0, 32'h0, 1);

`ifdef IF_PERF_CNT_EN
        // 3 stall cycles followed by 4 pops.
        do_reset();
        repeat (2) step(1, 1, 0, 32'h0, 1);
        repeat (3) step(1, 0, 0, 32'h0, 1);
        repeat (4) step(1, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 1);
        chk("perf_fetch_4", perf_fetch_cnt, 32'd4);
        chk("perf_stall_3", perf_stall_cnt, 32'd3);
`endif

        // Randomised traffic: back-pressure, variable latency, redirects, resets.
        do_reset();
        pops_before = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                pops_before += n_pops;
                do_reset();
            end
            rdy   = ($urandom_range(0, 9) < 7);
            idr   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 29) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                : 32'($urandom);
            step(rdy, idr, redir, rpc, $urandom_range(1, 3));
        end
        chk("progress", {31'b0, (pops_before + n_pops) > 500}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
